rx_correlation_scheduler: RTL and testbench

Sequencer placed in front of a single rx_correlation_unit. It buffers the filtered sample stream in a delay line and drives the unit's enable, new-sample trigger, current sample and sample-plus-ten. It captures each per-bit result pair and accumulates the pairs over a window of NUM_BITS results. At window end it emits one correlation pair to the peak-detection stage.

---
 rtl/rx_corr_pkg.sv | 16 +
 rtl/rx_sample_delay_line.sv | 32 +++
 rtl/rx_correlation_scheduler.sv | 172 +++++++++++++++++
 tb/tb_rx_correlation_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_corr_pkg.sv
// Shared constants and state encoding for the rx correlation scheduler.
package rx_corr_pkg;

    localparam int unsigned SAMPLE_W        = 16;
    localparam int unsigned RESULT_W        = 17;
    localparam int unsigned DEFAULT_LAG     = 10;
    localparam int unsigned DEFAULT_TIMEOUT = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFill    = 2'd1,
        StRun     = 2'd2,
        StWaitBit = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rx_sample_delay_line.sv
// Shift-register delay line: tap 0 is the newest sample, tap DEPTH-1 the oldest.
module rx_sample_delay_line #(
    parameter int unsigned DEPTH = 11,
    parameter int unsigned WIDTH = 16
) (
    input  logic             crx_clk,
    input  logic             rrx_rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] newest,
    output logic [WIDTH-1:0] oldest
);

    logic [WIDTH-1:0] taps_q [DEPTH];

    // Clear has priority over shifting so an abort never leaves stale samples behind.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) taps_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) taps_q[i] <= '0;
        end else if (shift_en) begin
            taps_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) taps_q[i] <= taps_q[i-1];
        end
    end

    assign newest = taps_q[0];
    assign oldest = taps_q[DEPTH-1];

endmodule

// File: rtl/rx_correlation_scheduler.sv
// Feeds one rx_correlation_unit from a sample delay line and sums its per-bit
// result pairs over a window of NUM_BITS bits.
module rx_correlation_scheduler
    import rx_corr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 10,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned LAG      = DEFAULT_LAG,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       istart,
    input  logic                       istop,
    input  logic                       isample_valid,
    input  logic signed [SAMPLE_W-1:0] isample,
    output logic                       oen,
    output logic                       onew_sample_trig,
    output logic signed [SAMPLE_W-1:0] osample,
    output logic signed [SAMPLE_W-1:0] osample_plus_ten,
    input  logic                       ibit_ready,
    input  logic signed [RESULT_W-1:0] iresult_0,
    input  logic signed [RESULT_W-1:0] iresult_1,
    output logic                       ocorr_valid,
    output logic signed [ACC_W-1:0]    ocorr_0,
    output logic signed [ACC_W-1:0]    ocorr_1,
    output logic                       ooverrun,
    output logic                       otimeout
);

    localparam int unsigned CntW  = $clog2(NUM_BITS + 1);
    localparam int unsigned FillW = $clog2(LAG + 2);
    localparam int unsigned WaitW = $clog2(TIMEOUT + 2);

    rx_state_e               state_q;
    logic [CntW-1:0]         bit_cnt_q;
    logic [FillW-1:0]        fill_cnt_q;
    logic [WaitW-1:0]        wait_cnt_q;
    logic signed [ACC_W-1:0] acc_0_q;
    logic signed [ACC_W-1:0] acc_1_q;

    logic                    accept;
    logic                    abort;
    logic                    got_bit;
    logic                    timed_out;
    logic                    capture;
    logic                    window_end;
    logic [CntW-1:0]         bit_cnt_inc;
    logic signed [ACC_W-1:0] add_0;
    logic signed [ACC_W-1:0] add_1;
    logic signed [ACC_W-1:0] sum_0;
    logic signed [ACC_W-1:0] sum_1;

    assign accept = isample_valid && !istop && ((state_q == StFill) || (state_q == StRun));
    assign abort  = istop && (state_q != StIdle);

    // A sample arriving while the unit is still busy is dropped and flagged immediately.
    assign ooverrun = (state_q == StWaitBit) && isample_valid;

    rx_sample_delay_line #(
        .DEPTH (LAG + 1),
        .WIDTH (SAMPLE_W)
    ) u_delay_line (
        .crx_clk  (crx_clk),
        .rrx_rst  (rrx_rst),
        .shift_en (accept),
        .clear    (abort),
        .din      (isample),
        .newest   (osample_plus_ten),
        .oldest   (osample)
    );

    // Capture decision: the unit answered, or it stayed silent for TIMEOUT cycles after the
    // trigger cycle (wait_cnt_q is 0 during the trigger cycle itself).
    always_comb begin
        got_bit     = (state_q == StWaitBit) && ibit_ready;
        timed_out   = (state_q == StWaitBit) && !ibit_ready && (wait_cnt_q == WaitW'(TIMEOUT));
        capture     = got_bit || timed_out;
        bit_cnt_inc = bit_cnt_q + CntW'(1);
        window_end  = capture && (bit_cnt_inc == CntW'(NUM_BITS));
        add_0       = '0;
        add_1       = '0;
        if (got_bit) begin
            add_0 = {{(ACC_W - RESULT_W){iresult_0[RESULT_W-1]}}, iresult_0};
            add_1 = {{(ACC_W - RESULT_W){iresult_1[RESULT_W-1]}}, iresult_1};
        end
        sum_0 = acc_0_q + add_0;
        sum_1 = acc_1_q + add_1;
    end

    // Sequencer FSM with registered outputs; istop overrides everything outside IDLE.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state_q          <= StIdle;
            bit_cnt_q        <= '0;
            fill_cnt_q       <= '0;
            wait_cnt_q       <= '0;
            acc_0_q          <= '0;
            acc_1_q          <= '0;
            oen              <= 1'b0;
            onew_sample_trig <= 1'b0;
            ocorr_valid      <= 1'b0;
            ocorr_0          <= '0;
            ocorr_1          <= '0;
            otimeout         <= 1'b0;
        end else begin
            onew_sample_trig <= 1'b0;
            ocorr_valid      <= 1'b0;
            if (abort) begin
                state_q    <= StIdle;
                oen        <= 1'b0;
                bit_cnt_q  <= '0;
                fill_cnt_q <= '0;
                wait_cnt_q <= '0;
                acc_0_q    <= '0;
                acc_1_q    <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (istart && !istop) begin
                            state_q    <= StFill;
                            otimeout   <= 1'b0;
                            fill_cnt_q <= '0;
                        end
                    end
                    StFill: begin
                        if (isample_valid) begin
                            if (fill_cnt_q == FillW'(LAG)) begin
                                // Delay line now full: this sample is issued like any RUN sample.
                                state_q          <= StWaitBit;
                                oen              <= 1'b1;
                                onew_sample_trig <= 1'b1;
                                wait_cnt_q       <= '0;
                            end else begin
                                fill_cnt_q <= fill_cnt_q + FillW'(1);
                            end
                        end
                    end
                    StRun: begin
                        if (isample_valid) begin
                            state_q          <= StWaitBit;
                            onew_sample_trig <= 1'b1;
                            wait_cnt_q       <= '0;
                        end
                    end
                    StWaitBit: begin
                        if (capture) begin
                            state_q <= StRun;
                            if (timed_out) otimeout <= 1'b1;
                            if (window_end) begin
                                ocorr_0     <= sum_0;
                                ocorr_1     <= sum_1;
                                ocorr_valid <= 1'b1;
                                acc_0_q     <= '0;
                                acc_1_q     <= '0;
                                bit_cnt_q   <= '0;
                            end else begin
                                acc_0_q   <= sum_0;
                                acc_1_q   <= sum_1;
                                bit_cnt_q <= bit_cnt_inc;
                            end
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WaitW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_correlation_scheduler.sv
// Directed bench for rx_correlation_scheduler with a behavioural reference model.
module tb_rx_correlation_scheduler;

    localparam int NB  = 2;
    localparam int LAG = 10;
    localparam int TO  = 4;

    logic               crx_clk = 1'b0;
    logic               rrx_rst = 1'b0;
    logic               istart, istop, isample_valid;
    logic signed [15:0] isample;
    logic               oen, onew_sample_trig;
    logic signed [15:0] osample, osample_plus_ten;
    logic               ibit_ready;
    logic signed [16:0] iresult_0, iresult_1;
    logic               ocorr_valid;
    logic signed [23:0] ocorr_0, ocorr_1;
    logic               ooverrun, otimeout;

    rx_correlation_scheduler #(
        .NUM_BITS (NB),
        .ACC_W    (24),
        .LAG      (LAG),
        .TIMEOUT  (TO)
    ) dut (
        .crx_clk          (crx_clk),
        .rrx_rst          (rrx_rst),
        .istart           (istart),
        .istop            (istop),
        .isample_valid    (isample_valid),
        .isample          (isample),
        .oen              (oen),
        .onew_sample_trig (onew_sample_trig),
        .osample          (osample),
        .osample_plus_ten (osample_plus_ten),
        .ibit_ready       (ibit_ready),
        .iresult_0        (iresult_0),
        .iresult_1        (iresult_1),
        .ocorr_valid      (ocorr_valid),
        .ocorr_0          (ocorr_0),
        .ocorr_1          (ocorr_1),
        .ooverrun         (ooverrun),
        .otimeout         (otimeout)
    );

    always #5 crx_clk = ~crx_clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;
    int trig_cnt  = 0;
    int valid_cnt = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sample history, outstanding-bit age and running sums.
    bit    m_on, m_busy;
    int    m_nacc, m_bits, m_age;
    int    m_acc0, m_acc1;
    int    hist [LAG+1];
    bit    e_trig, e_valid, e_to, e_en;
    int    e_c0, e_c1;

    task automatic m_clear_line();
        for (int i = 0; i <= LAG; i++) hist[i] = 0;
    endtask

    task automatic m_reset();
        m_on = 0; m_busy = 0; m_nacc = 0; m_bits = 0; m_age = 0;
        m_acc0 = 0; m_acc1 = 0;
        m_clear_line();
        e_trig = 0; e_valid = 0; e_to = 0; e_en = 0; e_c0 = 0; e_c1 = 0;
    endtask

    task automatic m_step();
        e_trig  = 0;
        e_valid = 0;
        if (!m_on) begin
            if (istart && !istop) begin
                m_on = 1; e_to = 0; m_nacc = 0;
            end
        end else if (istop) begin
            m_on = 0; m_busy = 0; m_nacc = 0; m_bits = 0; m_acc0 = 0; m_acc1 = 0;
            m_clear_line();
        end else if (m_busy) begin
            m_age++;
            if (ibit_ready || m_age > TO) begin
                if (ibit_ready) begin
                    m_acc0 += int'(iresult_0);
                    m_acc1 += int'(iresult_1);
                end else begin
                    e_to = 1;
                end
                m_busy = 0;
                m_bits++;
                if (m_bits == NB) begin
                    e_c0 = m_acc0; e_c1 = m_acc1; e_valid = 1;
                    m_acc0 = 0; m_acc1 = 0; m_bits = 0;
                end
            end
        end else if (isample_valid) begin
            for (int i = LAG; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(isample);
            m_nacc++;
            if (m_nacc > LAG) begin
                m_busy = 1; m_age = 0; e_trig = 1;
            end
        end
        e_en = m_on && (m_nacc > LAG);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge crx_clk or posedge rrx_rst);
            if (rrx_rst) m_reset();
            else m_step();
        end
    end

    // Compare every output against the model on the falling edge.
    initial forever begin
        @(negedge crx_clk);
        if (chk_en) begin
            check("oen", oen, e_en);
            check("trig", onew_sample_trig, e_trig);
            check("osample", osample, hist[LAG]);
            check("osample_plus_ten", osample_plus_ten, hist[0]);
            check("ocorr_valid", ocorr_valid, e_valid);
            check("ocorr_0", ocorr_0, e_c0);
            check("ocorr_1", ocorr_1, e_c1);
            check("otimeout", otimeout, e_to);
            check("ooverrun", ooverrun, m_on && m_busy && isample_valid);
            if (onew_sample_trig) trig_cnt++;
            if (ocorr_valid) valid_cnt++;
        end
    end

    // Correlation unit stand-in: answers resp_lat cycles after a trigger, or never if < 0.
    int resp_lat = 1;
    int cd       = -1;
    int r0_q[$]  = '{100, -30, 1, 3, 10, -1, 50, 9, 5, 7};
    int r1_q[$]  = '{-5, 7, 2, 4, 20, -2, -50, 9, 6, 8};

    initial begin
        ibit_ready = 1'b0; iresult_0 = '0; iresult_1 = '0;
        forever begin
            @(posedge crx_clk); #1;
            ibit_ready = 1'b0;
            if (cd == 0) begin
                ibit_ready = 1'b1;
                iresult_0  = (r0_q.size() > 0) ? 17'(r0_q.pop_front()) : '0;
                iresult_1  = (r1_q.size() > 0) ? 17'(r1_q.pop_front()) : '0;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (onew_sample_trig && resp_lat >= 0) cd = resp_lat;
        end
    end

    task automatic tick();
        @(posedge crx_clk); #1;
    endtask

    task automatic send(input int v);
        isample_valid = 1'b1;
        isample       = 16'(v);
        tick();
        isample_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ocorr_valid && n < 40) begin
            tick();
            n++;
        end
        check(name, ocorr_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0, v0;

    initial begin
        istart = 0; istop = 0; isample_valid = 0; isample = '0;
        #1 rrx_rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge crx_clk);
        #1 rrx_rst = 1'b0;
        check("rst_oen", oen, 0);
        check("rst_trig", onew_sample_trig, 0);
        check("rst_valid", ocorr_valid, 0);
        check("rst_corr0", ocorr_0, 0);
        check("rst_timeout", otimeout, 0);

        // Fill: no trigger until the 11th sample.
        istart = 1; tick(); istart = 0;
        t0 = trig_cnt;
        for (int v = 1; v <= 10; v++) begin
            send(v);
            repeat (3) tick();
        end
        check("fill_no_trig", trig_cnt - t0, 0);
        check("fill_oen", oen, 0);
        send(11);
        check("first_trig", onew_sample_trig, 1);
        check("first_osample", osample, 1);
        check("first_plus_ten", osample_plus_ten, 11);

        // Window 1: (100,-5) + (-30,7).
        repeat (4) tick();
        send(12);
        wait_valid("win1_valid");
        check("win1_corr0", ocorr_0, 70);
        check("win1_corr1", ocorr_1, 2);

        // Window 2 restarts from zero: (1,2) + (3,4).
        repeat (3) tick();
        send(13);
        repeat (4) tick();
        send(14);
        wait_valid("win2_valid");
        check("win2_corr0", ocorr_0, 4);
        check("win2_corr1", ocorr_1, 6);

        // Overrun: sample 16 lands one cycle after the trigger of 15 and is dropped.
        repeat (3) tick();
        send(15);
        isample_valid = 1'b1;
        isample       = 16'sd16;
        @(negedge crx_clk);
        check("overrun_pulse", ooverrun, 1);
        tick();
        isample_valid = 1'b0;
        repeat (4) tick();
        send(17);
        check("after_drop_osample", osample, 6);
        check("after_drop_plus_ten", osample_plus_ten, 17);
        wait_valid("win3_valid");
        check("win3_corr0", ocorr_0, 9);
        check("win3_corr1", ocorr_1, 18);

        // Timeout: the unit never answers sample 18.
        repeat (3) tick();
        resp_lat = -1;
        send(18);
        repeat (4) tick();
        check("timeout_not_yet", otimeout, 0);
        tick();
        check("timeout_set", otimeout, 1);
        check("timeout_oen", oen, 1);
        resp_lat = 1;
        tick();
        send(19);
        check("run_after_timeout", onew_sample_trig, 1);
        wait_valid("win4_valid");
        check("win4_corr0", ocorr_0, 50);
        check("win4_corr1", ocorr_1, -50);

        // Abort with one bit accumulated, istart and istop together.
        repeat (3) tick();
        send(20);
        repeat (4) tick();
        v0 = valid_cnt;
        istart = 1; istop = 1; tick(); istart = 0; istop = 0;
        check("stop_oen", oen, 0);
        check("stop_line_clear", osample_plus_ten, 0);
        repeat (6) tick();
        check("stop_no_valid", valid_cnt - v0, 0);
        check("stop_timeout_sticky", otimeout, 1);
        istart = 1; tick(); istart = 0;
        check("start_clears_timeout", otimeout, 0);
        for (int v = 101; v <= 110; v++) begin
            send(v);
            repeat (3) tick();
        end
        send(111);
        check("refill_osample", osample, 101);
        check("refill_plus_ten", osample_plus_ten, 111);
        repeat (4) tick();
        send(112);
        wait_valid("win5_valid");
        check("win5_corr0", ocorr_0, 12);
        check("win5_corr1", ocorr_1, 14);

        // Asynchronous reset mid-RUN.
        repeat (2) tick();
        #3 rrx_rst = 1'b1;
        repeat (2) @(posedge crx_clk);
        #1 rrx_rst = 1'b0;
        check("mid_rst_oen", oen, 0);
        check("mid_rst_corr0", ocorr_0, 0);
        check("mid_rst_corr1", ocorr_1, 0);
        check("mid_rst_osample", osample, 0);
        t0 = trig_cnt;
        for (int v = 1; v <= 11; v++) begin
            send(v);
            repeat (3) tick();
        end
        check("idle_no_trig", trig_cnt - t0, 0);
        check("idle_oen", oen, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
